// File: rtl/if_stage.sv
// Instruction fetch: one outstanding word read, single IF/ID register with valid/ready.
// Zero-wait bus gives id_valid two cycles after the grant; a full slot holds the request off and stalls the PC.
module if_stage #(
   parameter int          PC_W = 32,
   parameter logic [31:0] NOP  = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_in,
   output logic            pc_stall,
   input  logic            flush,
   output logic            ibus_req,
   output logic [PC_W-1:0] ibus_addr,
   input  logic            ibus_gnt,
   input  logic            ibus_rvalid,
   input  logic [31:0]     ibus_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [PC_W-1:0] id_pc,
   output logic [31:0]     id_instr,
   output logic            id_fault
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_FAULT} state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] req_pc;
   logic            slot_free;
   logic            misaligned;
   logic            load_fetch;
   logic            load_fault;
   logic            req_accept;

   assign slot_free  = !id_valid || id_ready;
   assign misaligned = pc_in[1:0] != 2'b00;
   assign ibus_addr  = pc_in;
   assign req_accept = (state == S_REQ) && ibus_req && ibus_gnt;
   assign pc_stall   = !req_accept;

   always_comb begin
      state_nxt  = state;
      ibus_req   = 1'b0;
      load_fetch = 1'b0;
      load_fault = 1'b0;
      case (state)
         S_REQ: begin
            if (!flush && slot_free) begin
               if (misaligned) begin
                  load_fault = 1'b1;
                  state_nxt  = S_FAULT;
               end else begin
                  ibus_req = 1'b1;
                  if (ibus_gnt) state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (ibus_rvalid) begin
               load_fetch = !flush;
               state_nxt  = S_REQ;
            end else if (flush) begin
               state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (ibus_rvalid) state_nxt = S_REQ;
         end
         S_FAULT: begin
            if (flush) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
      // Reset abandons any request; a late response then lands in REQ and is ignored.
      if (rst) begin
         ibus_req   = 1'b0;
         load_fetch = 1'b0;
         load_fault = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_REQ;
         req_pc <= '0;
      end else begin
         state <= state_nxt;
         if (req_accept) req_pc <= pc_in;
      end
   end

   // Flush wins over a load; a consumed entry clears unless replaced in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_fault <= 1'b0;
         id_pc    <= '0;
         id_instr <= NOP;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (load_fetch) begin
         id_valid <= 1'b1;
         id_pc    <= req_pc;
         id_instr <= ibus_rdata;
         id_fault <= 1'b0;
      end else if (load_fault) begin
         id_valid <= 1'b1;
         id_pc    <= pc_in;
         id_instr <= NOP;
         id_fault <= 1'b1;
      end else if (id_ready) begin
         id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: PC and bus are driven cycle by cycle with hand-computed expectations.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_stall;
   logic        flush;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_gnt;
   logic        ibus_rvalid;
   logic [31:0] ibus_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_fault;

   int total = 0;
   int fails = 0;

   localparam logic [31:0] NOP_W = 32'h0000_0013;
   localparam logic [31:0] XK    = 32'hA5A5_0000;

   if_stage #(.PC_W(32), .NOP(NOP_W)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_stall(pc_stall), .flush(flush),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_instr(id_instr), .id_fault(id_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [31:0] pc, input logic fl,
                        input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic rdy);
      rst = r; pc_in = pc; flush = fl; ibus_gnt = gnt;
      ibus_rvalid = rv; ibus_rdata = rd; id_ready = rdy;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 1);
      step(); step();
      // reset state
      chk("rst_req",    {31'd0, ibus_req}, 0);
      chk("rst_stall",  {31'd0, pc_stall}, 1);
      chk("rst_valid",  {31'd0, id_valid}, 0);
      chk("rst_fault",  {31'd0, id_fault}, 0);
      chk("rst_pc",     id_pc, 0);
      chk("rst_instr",  id_instr, NOP_W);

      // zero-wait fetch: first cycle after reset release
      step(); drive(0, 32'h0, 0, 1, 0, 0, 1);
      chk("zw_req0",   {31'd0, ibus_req}, 1);
      chk("zw_addr0",  ibus_addr, 32'h0);
      chk("zw_stall0", {31'd0, pc_stall}, 0);
      step(); drive(0, 32'h4, 0, 0, 1, 32'h0 ^ XK, 1);
      chk("zw_req1",   {31'd0, ibus_req}, 0);
      chk("zw_stall1", {31'd0, pc_stall}, 1);
      chk("zw_valid1", {31'd0, id_valid}, 0);
      step(); drive(0, 32'h4, 0, 1, 0, 0, 1);
      chk("zw_valid2", {31'd0, id_valid}, 1);
      chk("zw_pc2",    id_pc, 32'h0);
      chk("zw_instr2", id_instr, 32'hA5A5_0000);
      chk("zw_fault2", {31'd0, id_fault}, 0);
      chk("zw_req2",   {31'd0, ibus_req}, 1);
      chk("zw_addr2",  ibus_addr, 32'h4);
      step(); drive(0, 32'h8, 0, 0, 1, 32'h4 ^ XK, 1);
      chk("zw_valid3", {31'd0, id_valid}, 0);
      step(); drive(0, 32'h8, 0, 0, 0, 0, 1);
      chk("zw_valid4", {31'd0, id_valid}, 1);
      chk("zw_pc4",    id_pc, 32'h4);
      chk("zw_instr4", id_instr, 32'hA5A5_0004);

      // grant back-pressure: this cycle and two more with gnt low
      for (int i = 0; i < 3; i++) begin
         if (i != 0) begin step(); drive(0, 32'h8, 0, 0, 0, 0, 1); end
         chk("gbp_req",   {31'd0, ibus_req}, 1);
         chk("gbp_addr",  ibus_addr, 32'h8);
         chk("gbp_stall", {31'd0, pc_stall}, 1);
      end
      step(); drive(0, 32'h8, 0, 1, 0, 0, 1);
      chk("gbp_stall_gnt", {31'd0, pc_stall}, 0);

      // decode back-pressure
      step(); drive(0, 32'hC, 0, 0, 1, 32'h0000_0093, 0);
      for (int i = 0; i < 4; i++) begin
         step(); drive(0, 32'hC, 0, 0, 0, 0, 0);
         chk("dbp_req",   {31'd0, ibus_req}, 0);
         chk("dbp_valid", {31'd0, id_valid}, 1);
         chk("dbp_pc",    id_pc, 32'h8);
         chk("dbp_instr", id_instr, 32'h0000_0093);
         chk("dbp_stall", {31'd0, pc_stall}, 1);
      end
      step(); drive(0, 32'hC, 0, 1, 0, 0, 1);
      chk("dbp_resume_req",  {31'd0, ibus_req}, 1);
      chk("dbp_resume_addr", ibus_addr, 32'hC);
      chk("dbp_resume_stall", {31'd0, pc_stall}, 0);

      // flush while waiting; killed response two cycles later
      step(); drive(0, 32'h10, 1, 0, 0, 0, 1);
      chk("fl_req0", {31'd0, ibus_req}, 0);
      step(); drive(0, 32'h100, 0, 1, 0, 0, 1);
      chk("fl_req1",   {31'd0, ibus_req}, 0);
      chk("fl_stall1", {31'd0, pc_stall}, 1);
      chk("fl_valid1", {31'd0, id_valid}, 0);
      step(); drive(0, 32'h100, 0, 0, 1, 32'hDEAD_BEEF, 1);
      chk("fl_req2", {31'd0, ibus_req}, 0);
      step(); drive(0, 32'h100, 0, 1, 0, 0, 1);
      chk("fl_valid3", {31'd0, id_valid}, 0);
      chk("fl_instr3", id_instr, 32'h0000_0093);
      chk("fl_req3",   {31'd0, ibus_req}, 1);
      chk("fl_addr3",  ibus_addr, 32'h100);
      step(); drive(0, 32'h104, 0, 0, 1, 32'h100 ^ XK, 1);
      step(); drive(0, 32'h104, 1, 0, 0, 0, 1);
      chk("fl_valid5", {31'd0, id_valid}, 1);
      chk("fl_pc5",    id_pc, 32'h100);
      chk("fl_instr5", id_instr, 32'hA5A5_0100);

      // misaligned PC after redirect
      step(); drive(0, 32'h102, 0, 1, 0, 0, 1);
      chk("mis_valid0", {31'd0, id_valid}, 0);
      chk("mis_req0",   {31'd0, ibus_req}, 0);
      chk("mis_stall0", {31'd0, pc_stall}, 1);
      step(); drive(0, 32'h102, 0, 1, 0, 0, 1);
      chk("mis_valid1", {31'd0, id_valid}, 1);
      chk("mis_fault1", {31'd0, id_fault}, 1);
      chk("mis_instr1", id_instr, NOP_W);
      chk("mis_pc1",    id_pc, 32'h102);
      chk("mis_req1",   {31'd0, ibus_req}, 0);
      chk("mis_stall1", {31'd0, pc_stall}, 1);
      for (int i = 0; i < 2; i++) begin
         step(); drive(0, 32'h102, 0, 1, 0, 0, 1);
         chk("mis_hold_req",   {31'd0, ibus_req}, 0);
         chk("mis_hold_stall", {31'd0, pc_stall}, 1);
      end
      drive(0, 32'h102, 1, 1, 0, 0, 1);
      step(); drive(0, 32'h200, 0, 1, 0, 0, 1);
      chk("mis_after_req",  {31'd0, ibus_req}, 1);
      chk("mis_after_addr", ibus_addr, 32'h200);

      // reset mid-fetch, then a late response
      step(); drive(1, 32'h204, 0, 0, 0, 0, 1);
      chk("rmf_req",   {31'd0, ibus_req}, 0);
      chk("rmf_stall", {31'd0, pc_stall}, 1);
      step(); drive(0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 1);
      chk("rmf_valid0", {31'd0, id_valid}, 0);
      step(); drive(0, 32'h0, 0, 1, 0, 0, 1);
      chk("rmf_valid1", {31'd0, id_valid}, 0);
      chk("rmf_instr1", id_instr, NOP_W);
      chk("rmf_req1",   {31'd0, ibus_req}, 1);
      chk("rmf_addr1",  ibus_addr, 32'h0);
      step(); drive(0, 32'h4, 0, 0, 1, 32'h0 ^ XK, 1);
      step(); drive(0, 32'h4, 0, 0, 0, 0, 1);
      chk("rmf_valid3", {31'd0, id_valid}, 1);
      chk("rmf_pc3",    id_pc, 32'h0);
      chk("rmf_instr3", id_instr, 32'hA5A5_0000);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
